cereal_rx: RTL and testbench

CEREAL_RX -- requirements
Module: cereal_rx

---
 rtl/cereal_pkg.sv | 23 ++
 rtl/sync_ff.sv | 38 +++
 rtl/cereal_rx.sv | 163 ++++++++++++++++
 tb/tb_cereal_rx.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/cereal_pkg.sv
// Shared definitions for the cereal UART receiver and transmitter.
// Holds the frame state encoding and the default bit timing.
// Pure declarations: no logic, no latency, no backpressure.
package cereal_pkg;

  // Default bit period in sysclk cycles: 9600 baud from a 50 MHz clock.
  localparam int CEREAL_CLKS_PER_BIT = 5208;

  // Default number of synchronizer flops on the serial input.
  localparam int CEREAL_SYNC_STAGES = 2;

  // Data bits per 8N1 frame.
  localparam int CEREAL_DATA_BITS = 8;

  // Frame state encoding, shared by RX and TX.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } cereal_state_t;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for one asynchronous single-bit input.
// Latency: DEPTH sysclk cycles from d to q.
// No backpressure: samples every cycle.
//
// Ports:
//   clk - sampling clock
//   rst - asynchronous active-high reset, loads RST_VAL into every flop
//   d   - asynchronous input
//   q   - synchronized output
module sync_ff #(
  parameter int   DEPTH   = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] stage;

  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge clk or posedge rst) begin
        if (rst) stage <= RST_VAL;
        else     stage <= d;
      end
    end else begin : g_chain
      always_ff @(posedge clk or posedge rst) begin
        if (rst) stage <= {DEPTH{RST_VAL}};
        else     stage <= {stage[DEPTH-2:0], d};
      end
    end
  endgenerate

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/cereal_rx.sv
// 8N1 UART receiver with single-entry output holding register.
// Latency: valid rises the cycle after the stop-bit mid sample (~9.5 bits + SYNC_STAGES+1).
// No backpressure on the line: an unacknowledged byte is overwritten and flagged as overrun.
//
// Ports:
//   sysclk    - system clock, all state changes on its rising edge
//   rst       - asynchronous active-high reset
//   rx        - asynchronous serial line, idles high, LSB first
//   data      - last good byte received
//   valid     - data holds a byte not yet acknowledged
//   ack       - consumer takes data; clears valid
//   frame_err - sticky: a stop bit was sampled low
//   overrun   - sticky: a byte completed while valid was still set
//   status    - 1 when idle, 0 while a frame is in progress
module cereal_rx
  import cereal_pkg::*;
#(
  parameter int CLKS_PER_BIT = CEREAL_CLKS_PER_BIT,
  parameter int SYNC_STAGES  = CEREAL_SYNC_STAGES
) (
  input  logic       sysclk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ack,
  output logic       frame_err,
  output logic       overrun,
  output logic       status
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);
  // Mid point of the start bit; data and stop samples follow at whole
  // bit periods from here, so they all land mid-bit.
  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);

  logic          rxs;
  logic          rxs_prev;

  cereal_state_t state,     state_nxt;
  logic [TW-1:0] timer,     timer_nxt;
  logic [2:0]    idx,       idx_nxt;
  logic [7:0]    shreg,     shreg_nxt;
  logic [7:0]    data_nxt;
  logic          valid_nxt;
  logic          frame_err_nxt;
  logic          overrun_nxt;
  logic          byte_done;

  sync_ff #(
    .DEPTH   (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_sync (
    .clk (sysclk),
    .rst (rst),
    .d   (rx),
    .q   (rxs)
  );

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      timer     <= '0;
      idx       <= 3'd0;
      shreg     <= 8'h00;
      data      <= 8'h00;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      rxs_prev  <= 1'b1;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      idx       <= idx_nxt;
      shreg     <= shreg_nxt;
      data      <= data_nxt;
      valid     <= valid_nxt;
      frame_err <= frame_err_nxt;
      overrun   <= overrun_nxt;
      rxs_prev  <= rxs;
    end
  end

  always_comb begin
    state_nxt     = state;
    timer_nxt     = timer;
    idx_nxt       = idx;
    shreg_nxt     = shreg;
    data_nxt      = data;
    valid_nxt     = valid;
    frame_err_nxt = frame_err;
    overrun_nxt   = overrun;
    byte_done     = 1'b0;

    case (state)
      ST_IDLE: begin
        // rxs_prev tracks the line even while idle, so a start edge right
        // after the previous stop sample is still seen.
        if (rxs_prev && !rxs) begin
          state_nxt = ST_START;
          timer_nxt = '0;
        end
      end

      ST_START: begin
        if (timer == T_HALF) begin
          timer_nxt = '0;
          if (!rxs) begin
            state_nxt = ST_DATA;
            idx_nxt   = 3'd0;
          end else begin
            // Line went back high before mid start bit: treat as a glitch.
            state_nxt = ST_IDLE;
          end
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end

      ST_DATA: begin
        if (timer == T_FULL) begin
          timer_nxt      = '0;
          shreg_nxt[idx] = rxs;
          // idx wraps 7 -> 0, leaving it ready for the next frame.
          idx_nxt        = idx + 3'd1;
          if (idx == 3'd7) state_nxt = ST_STOP;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end

      ST_STOP: begin
        if (timer == T_FULL) begin
          timer_nxt = '0;
          state_nxt = ST_IDLE;
          if (rxs) byte_done     = 1'b1;
          else     frame_err_nxt = 1'b1;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
        timer_nxt = '0;
      end
    endcase

    // A completing byte wins over a same-cycle ack: the consumer took the
    // old byte, the new one is pending, and nothing was lost.
    if (byte_done) begin
      data_nxt  = shreg;
      valid_nxt = 1'b1;
      if (valid && !ack) overrun_nxt = 1'b1;
    end else if (ack) begin
      valid_nxt = 1'b0;
    end
  end

  assign status = (state == ST_IDLE);

endmodule

// File: tb/tb_cereal_rx.sv
// Directed bench for cereal_rx with CLKS_PER_BIT=16, SYNC_STAGES=2.
module tb_cereal_rx;

  localparam int CPB = 16;

  logic       sysclk;
  logic       rst;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       ack;
  logic       frame_err;
  logic       overrun;
  logic       status;

  int checks = 0;
  int errors = 0;

  cereal_rx #(
    .CLKS_PER_BIT (CPB),
    .SYNC_STAGES  (2)
  ) dut (
    .sysclk    (sysclk),
    .rst       (rst),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .ack       (ack),
    .frame_err (frame_err),
    .overrun   (overrun),
    .status    (status)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx  = 1'b1;
    ack = 1'b0;
    wait_clks(3);
    rst = 1'b0;
    wait_clks(2);
  endtask

  // Drives one full 8N1 frame; starts and ends 1 time unit after a rising edge.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_clks(CPB);
    end
    rx = stop_bit;
    wait_clks(CPB);
    rx = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    ack = 1'b0;
    #2;
    chk("rst_data",      int'(data),      'h00);
    chk("rst_valid",     int'(valid),     0);
    chk("rst_frame_err", int'(frame_err), 0);
    chk("rst_overrun",   int'(overrun),   0);
    chk("rst_status",    int'(status),    1);
    do_reset();

    // Good frame A5, no ack.
    fork
      send_byte(8'hA5, 1'b1);
      begin
        wait_clks(50);
        chk("a5_busy_status", int'(status), 0);
      end
    join
    wait_clks(4);
    chk("a5_data",      int'(data),      'hA5);
    chk("a5_valid",     int'(valid),     1);
    chk("a5_frame_err", int'(frame_err), 0);
    chk("a5_status",    int'(status),    1);
    ack = 1'b1;
    wait_clks(1);
    ack = 1'b0;
    wait_clks(1);
    chk("a5_ack_valid", int'(valid), 0);
    chk("a5_ack_data",  int'(data),  'hA5);

    // Four-cycle glitch on an idle line.
    rx = 1'b0;
    wait_clks(4);
    rx = 1'b1;
    wait_clks(30);
    chk("glitch_valid",     int'(valid),     0);
    chk("glitch_frame_err", int'(frame_err), 0);
    chk("glitch_overrun",   int'(overrun),   0);
    chk("glitch_status",    int'(status),    1);

    // Stop bit low.
    do_reset();
    send_byte(8'h3C, 1'b0);
    wait_clks(4);
    chk("ferr_frame_err", int'(frame_err), 1);
    chk("ferr_valid",     int'(valid),     0);
    chk("ferr_data",      int'(data),      'h00);
    chk("ferr_overrun",   int'(overrun),   0);

    // Back-to-back frames without ack.
    do_reset();
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    wait_clks(4);
    chk("ovr_data",      int'(data),      'h22);
    chk("ovr_valid",     int'(valid),     1);
    chk("ovr_overrun",   int'(overrun),   1);
    chk("ovr_frame_err", int'(frame_err), 0);

    // Ack in the same cycle the second byte completes (stop sample at edge 155).
    do_reset();
    send_byte(8'h55, 1'b1);
    fork
      send_byte(8'hAA, 1'b1);
      begin
        repeat (154) @(posedge sysclk);
        #1;
        chk("coin_pre_valid", int'(valid), 1);
        chk("coin_pre_data",  int'(data),  'h55);
        ack = 1'b1;
        wait_clks(1);
        ack = 1'b0;
      end
    join
    wait_clks(4);
    chk("coin_data",    int'(data),    'hAA);
    chk("coin_valid",   int'(valid),   1);
    chk("coin_overrun", int'(overrun), 0);

    // Reset during bit 4 of FF, then a clean 81.
    do_reset();
    fork
      send_byte(8'hFF, 1'b1);
      begin
        wait_clks(5 * CPB + 8);
        rst = 1'b1;
        wait_clks(2);
        rst = 1'b0;
        chk("midrst_data",   int'(data),   'h00);
        chk("midrst_valid",  int'(valid),  0);
        chk("midrst_status", int'(status), 1);
      end
    join
    wait_clks(4);
    chk("after_ff_valid", int'(valid), 0);
    send_byte(8'h81, 1'b1);
    wait_clks(4);
    chk("r81_data",      int'(data),      'h81);
    chk("r81_valid",     int'(valid),     1);
    chk("r81_frame_err", int'(frame_err), 0);
    chk("r81_overrun",   int'(overrun),   0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
